// File: rtl/hazard_response_ctrl_pkg.sv
// Shared constants for the load-use stall response controller: FSM encodings
// and the default watchdog threshold.
package hazard_response_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int MAX_STALL_DEFAULT = 4;

endpackage

// File: rtl/hazard_response_ctrl_if.sv
// Bundle between the hazard detector / branch comparator (master) and the
// stall response controller (slave), including its status and counters.
interface hazard_response_ctrl_if #(
  parameter int RUN_W = 3,
  parameter int CNT_W = 32
);
  logic             stall_req;
  logic             branch_taken_ID;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic [RUN_W-1:0] stall_run;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stall_req, branch_taken_ID,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, halted,
           stall_run, stall_cycles, flush_count
  );

  modport slave (
    input  stall_req, branch_taken_ID,
    output pc_we, ifid_we, ifid_flush, idex_bubble, halted,
           stall_run, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_response_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_response_ctrl.sv
// Turns stall requests and ID-stage branch decisions into PC / IF/ID / ID/EX
// controls, with a runaway-stall watchdog and saturating perf counters.
module hazard_response_ctrl
  import hazard_response_ctrl_pkg::*;
#(
  parameter int MAX_STALL = MAX_STALL_DEFAULT,
  parameter int RUN_W     = 3,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_response_ctrl_if.slave bus
);

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_q, run_nxt, run_sat;
  logic [RUN_W:0]   run_inc;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign run_inc = {1'b0, run_q} + (RUN_W+1)'(1);
  assign run_sat = (run_q >= RUN_W'(MAX_STALL)) ? RUN_W'(MAX_STALL) : run_inc[RUN_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_PRIME;
      run_q <= '0;
    end else begin
      state <= state_nxt;
      run_q <= run_nxt;
    end
  end

  // Mealy decode: stall beats a same-cycle taken branch, whose operands are not yet valid
  always_comb begin
    state_nxt       = state;
    run_nxt         = run_q;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    bus.pc_we       = 1'b0;
    bus.ifid_we     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b1;
    bus.halted      = 1'b0;
    if (reset) begin
      bus.ifid_flush = 1'b1;
      state_nxt      = ST_PRIME;
      run_nxt        = '0;
    end else begin
      unique case (state)
        ST_PRIME: begin
          bus.pc_we      = 1'b1;
          bus.ifid_we    = 1'b1;
          bus.ifid_flush = 1'b1;
          run_nxt        = '0;
          state_nxt      = ST_RUN;
        end
        ST_RUN, ST_STALL: begin
          if (bus.stall_req) begin
            stall_inc = 1'b1;
            run_nxt   = run_sat;
            state_nxt = (run_inc == (RUN_W+1)'(MAX_STALL)) ? ST_HALT : ST_STALL;
          end else begin
            bus.pc_we       = 1'b1;
            bus.ifid_we     = 1'b1;
            bus.idex_bubble = 1'b0;
            bus.ifid_flush  = bus.branch_taken_ID;
            flush_inc       = bus.branch_taken_ID;
            run_nxt         = '0;
            state_nxt       = ST_RUN;
          end
        end
        ST_HALT: begin
          bus.halted = 1'b1;
        end
        default: state_nxt = ST_PRIME;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign bus.stall_run    = run_q;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;

endmodule
